fc_layer_seq: RTL
=================

Name: fc_layer_seq

Overview:
- Time-multiplexed, signed fully connected layer, parametrised in vector size, neuron count and MAC parallelism.
- Input activations stream in one element per cycle (valid/ready); outputs stream out one neuron per cycle (valid/ready).
- NUM_MAC multiply-accumulators share on-chip weight/bias storage, loaded through a word-addressed write port.
- Sits between feature-extraction stages and the classifier head; requantises accumulators back to ACTIV_BITS.

Parameters:
- INPUT_SIZE, 64, activations per input vector
- OUTPUT_SIZE, 16, neurons; must be a multiple of NUM_MAC
- ACTIV_BITS, 8, signed width of activations, weights and outputs
- ACC_BITS, 24, signed width of accumulators and biases
- NUM_MAC, 4, parallel MAC lanes

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous active-low
- wt_wr_en  in  1  weight write strobe
- wt_wr_addr  in  $clog2(OUTPUT_SIZE*INPUT_SIZE)  address = o*INPUT_SIZE+i
- wt_wr_data  in  ACTIV_BITS  signed weight
- bias_wr_en  in  1  bias write strobe
- bias_wr_addr  in  $clog2(OUTPUT_SIZE)  neuron index
- bias_wr_data  in  ACC_BITS  signed bias
- shift  in  5  arithmetic right-shift applied at requantisation; sampled at COMPUTE entry
- in_valid  in  1  input element valid
- in_ready  out  1  block accepts an input element
- in_data  in  ACTIV_BITS  signed activation
- out_valid  out  1  output element valid
- out_ready  in  1  downstream accepts output
- out_data  out  ACTIV_BITS  signed neuron result
- out_last  out  1  marks neuron OUTPUT_SIZE-1
- busy  out  1  high in COMPUTE or DRAIN

Behaviour:
- Reset: state=LOAD, in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, all counters 0. Weight/bias memories are not reset and retain contents across reset.
- Weight/bias writes take effect only when busy=0; writes with busy=1 are dropped.
- LOAD: in_ready=1. Each in_valid&&in_ready stores in_data at index cnt_i, then cnt_i++. Acceptance of element INPUT_SIZE-1 switches to COMPUTE on the next edge; shift is latched on that edge.
- COMPUTE: in_ready=0, busy=1. G = OUTPUT_SIZE/NUM_MAC groups; each group takes INPUT_SIZE cycles.
  - Lane m of group g handles neuron g*NUM_MAC+m.
  - At j=0: acc = bias + w*x. At j>0: acc += w*x. Full-precision signed product, sign-extended to ACC_BITS; accumulator wraps modulo 2^ACC_BITS.
  - After j=INPUT_SIZE-1, each lane writes req(acc) to the output buffer.
  - req(a) = a >>> shift, saturated to ACTIV_BITS (-128..127 at 8 bits).
- Latency: the last input is accepted at edge T; out_valid rises at edge T+G*INPUT_SIZE+1.
- DRAIN: out_valid=1, out_data=buffer[k], out_last=(k==OUTPUT_SIZE-1).
  - k advances only on out_valid&&out_ready; out_data holds stable while out_ready=0.
  - The handshake on k=OUTPUT_SIZE-1 returns to LOAD on the same edge: out_valid=0 and in_ready=1 from the next cycle.
- in_valid during COMPUTE/DRAIN is ignored (not stored).
- Reset asserted in any state aborts the vector and discards partial inputs, accumulators and outputs.

Optional Feature:
- Macro FC_RELU_EN.
  - Defined: ReLU after requantisation, out = max(req(acc), 0), so the range is 0..2^(ACTIV_BITS-1)-1.
  - Undefined: signed saturated output, no ReLU.

Test Plan:
- Parameters for all scenarios: INPUT_SIZE=4, OUTPUT_SIZE=4, NUM_MAC=2.
- Identity weights (w[o][o]=1, else 0), bias 0, shift 0, input [5,-3,100,7]:
  - with FC_RELU_EN -> [5,0,100,7]; without -> [5,-3,100,7].
  - out_valid rises 9 edges after the last input; out_last on the 4th output.
- All weights 127, input all 127, bias 0: acc=64516.
  - shift 0 -> all outputs 127.
  - shift 10 -> all outputs 63.
- Weights 0, biases [300,-300,4,-1], shift 2 -> [75,-75,1,-1] without ReLU; [75,0,1,0] with FC_RELU_EN.
- Backpressure: hold out_ready=0 for 3 cycles at k=1 -> out_data and out_last stable, in_ready=0; all 4 outputs delivered in order once released.
- Write weight 0x7F to address 0 during COMPUTE -> ignored; this vector and the next both produce the identity result.
- Assert rst_n=0 mid-COMPUTE -> out_valid=0, in_ready=1 after release; resending the vector without reloading gives the identity result.

Source files
------------

// File: rtl/fc_layer_seq_if.sv
// rtl/fc_layer_seq_if.sv - weight/bias write port and activation/result streams for fc_layer_seq
interface fc_layer_seq_if #(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = 16,
  parameter int ACTIV_BITS  = 8,
  parameter int ACC_BITS    = 24
) ();
  localparam int AW = $clog2(OUTPUT_SIZE * INPUT_SIZE);
  localparam int BW = $clog2(OUTPUT_SIZE);

  logic                         wt_wr_en;
  logic [AW-1:0]                wt_wr_addr;
  logic signed [ACTIV_BITS-1:0] wt_wr_data;
  logic                         bias_wr_en;
  logic [BW-1:0]                bias_wr_addr;
  logic signed [ACC_BITS-1:0]   bias_wr_data;
  logic [4:0]                   shift;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [ACTIV_BITS-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACTIV_BITS-1:0] out_data;
  logic                         out_last;
  logic                         busy;

  modport master (
    output wt_wr_en, wt_wr_addr, wt_wr_data,
    output bias_wr_en, bias_wr_addr, bias_wr_data,
    output shift, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  modport slave (
    input  wt_wr_en, wt_wr_addr, wt_wr_data,
    input  bias_wr_en, bias_wr_addr, bias_wr_data,
    input  shift, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - time-multiplexed signed fully connected layer; FC_RELU_EN adds ReLU after requantisation
module fc_layer_seq #(
  parameter int INPUT_SIZE  = 64,
  parameter int OUTPUT_SIZE = 16,
  parameter int ACTIV_BITS  = 8,
  parameter int ACC_BITS    = 24,
  parameter int NUM_MAC     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fc_layer_seq_if.slave  bus
);
  localparam int G  = OUTPUT_SIZE / NUM_MAC;
  localparam int AW = $clog2(OUTPUT_SIZE * INPUT_SIZE);
  localparam int BW = $clog2(OUTPUT_SIZE);
  localparam int JW = $clog2(INPUT_SIZE);
  localparam int GW = $clog2(G + 1);

  localparam logic signed [ACC_BITS-1:0] L_SAT_HI = ACC_BITS'((1 << (ACTIV_BITS - 1)) - 1);
  localparam logic signed [ACC_BITS-1:0] L_SAT_LO = ~L_SAT_HI;

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t r_state, w_state_nxt;

  logic signed [ACTIV_BITS-1:0] r_wt   [OUTPUT_SIZE*INPUT_SIZE];
  logic signed [ACC_BITS-1:0]   r_bias [OUTPUT_SIZE];
  logic signed [ACTIV_BITS-1:0] r_x    [INPUT_SIZE];
  logic signed [ACC_BITS-1:0]   r_acc  [NUM_MAC];
  logic signed [ACTIV_BITS-1:0] r_obuf [OUTPUT_SIZE];

  logic [JW-1:0] r_cnt_i;
  logic [JW-1:0] r_j;
  logic [GW-1:0] r_grp;
  logic [BW-1:0] r_k;
  logic [4:0]    r_shift;
  logic          r_wb_vld;
  logic [GW-1:0] r_wb_grp;

  logic w_in_ready, w_out_valid, w_busy;
  logic w_accept, w_last_in, w_mac_en, w_out_hs, w_out_end;

  logic [AW-1:0]              w_waddr   [NUM_MAC];
  logic [BW-1:0]              w_bidx    [NUM_MAC];
  logic signed [ACC_BITS-1:0] w_prod    [NUM_MAC];
  logic signed [ACC_BITS-1:0] w_acc_nxt [NUM_MAC];

  // Requantise: arithmetic shift, saturate to the activation range, optional ReLU.
  function automatic logic signed [ACTIV_BITS-1:0] f_req(
    input logic signed [ACC_BITS-1:0] a,
    input logic [4:0]                 s
  );
    logic signed [ACC_BITS-1:0] v;
    v = a >>> s;
    if (v > L_SAT_HI) v = L_SAT_HI;
    if (v < L_SAT_LO) v = L_SAT_LO;
`ifdef FC_RELU_EN
    if (v < 0) v = '0;
`else
`endif
    return v[ACTIV_BITS-1:0];
  endfunction

  assign w_accept  = w_in_ready && bus.in_valid;
  assign w_last_in = w_accept && (r_cnt_i == JW'(INPUT_SIZE - 1));
  assign w_mac_en  = (r_state == S_COMPUTE) && (r_grp != GW'(G));
  assign w_out_hs  = w_out_valid && bus.out_ready;
  assign w_out_end = w_out_hs && (r_k == BW'(OUTPUT_SIZE - 1));

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = w_busy;
  assign bus.out_data  = (r_state == S_DRAIN) ? r_obuf[r_k] : '0;
  assign bus.out_last  = (r_state == S_DRAIN) && (r_k == BW'(OUTPUT_SIZE - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_LOAD;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; COMPUTE ends one cycle after the last MAC so the final group is written back.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && (r_cnt_i == JW'(INPUT_SIZE - 1))) w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        w_busy = 1'b1;
        if (r_grp == GW'(G)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        if (bus.out_ready && (r_k == BW'(OUTPUT_SIZE - 1))) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  // Counters, latched shift and the writeback request for the group that just finished.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_i  <= '0;
      r_j      <= '0;
      r_grp    <= '0;
      r_k      <= '0;
      r_shift  <= '0;
      r_wb_vld <= 1'b0;
      r_wb_grp <= '0;
    end else begin
      r_wb_vld <= 1'b0;
      if (w_accept) r_cnt_i <= w_last_in ? '0 : r_cnt_i + 1'b1;
      if (w_last_in) begin
        r_shift <= bus.shift;
        r_j     <= '0;
        r_grp   <= '0;
      end
      if (w_mac_en) begin
        if (r_j == JW'(INPUT_SIZE - 1)) begin
          r_j      <= '0;
          r_grp    <= r_grp + 1'b1;
          r_wb_vld <= 1'b1;
          r_wb_grp <= r_grp;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end
      if (w_out_hs) r_k <= w_out_end ? '0 : r_k + 1'b1;
    end
  end

  // Per-lane weight/bias addressing and multiply-accumulate; j=0 seeds the accumulator with the bias.
  always_comb begin
    for (int m = 0; m < NUM_MAC; m++) begin
      w_waddr[m]   = AW'((int'(r_grp) * NUM_MAC + m) * INPUT_SIZE + int'(r_j));
      w_bidx[m]    = BW'(int'(r_grp) * NUM_MAC + m);
      w_prod[m]    = ACC_BITS'(r_wt[w_waddr[m]]) * ACC_BITS'(r_x[r_j]);
      w_acc_nxt[m] = ((r_j == '0) ? r_bias[w_bidx[m]] : r_acc[m]) + w_prod[m];
    end
  end

  // Weight/bias storage: no reset, writes accepted only while idle.
  always_ff @(posedge clk) begin
    if (bus.wt_wr_en && !w_busy)   r_wt[bus.wt_wr_addr]     <= bus.wt_wr_data;
    if (bus.bias_wr_en && !w_busy) r_bias[bus.bias_wr_addr] <= bus.bias_wr_data;
  end

  // Datapath storage: input vector, accumulators and requantised output buffer.
  always_ff @(posedge clk) begin
    if (w_accept) r_x[r_cnt_i] <= bus.in_data;
    for (int m = 0; m < NUM_MAC; m++) begin
      if (w_mac_en) r_acc[m] <= w_acc_nxt[m];
      if (r_wb_vld) r_obuf[BW'(int'(r_wb_grp) * NUM_MAC + m)] <= f_req(r_acc[m], r_shift);
    end
  end
endmodule
